// File: rtl/fp_fma_pkg.sv
// Shared constants and elaboration helpers for the FMA datapath adders.
// Default geometry is a 32-bit add resolved in 8-bit segments.
package fp_fma_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_SEG   = 8;

    // Number of pipeline stages needed to resolve a WIDTH-bit add SEG bits at a time.
    function automatic int calc_nstage(input int width, input int seg);
        return width / seg;
    endfunction

    // The segment geometry is only legal when SEG tiles WIDTH exactly.
    function automatic bit seg_cfg_ok(input int width, input int seg);
        return (seg > 32'sd0) && (width >= seg) && ((width % seg) == 32'sd0);
    endfunction

endpackage

// File: rtl/seg_pipe_adder_if.sv
// Valid/ready operand and result bundle of the segmented pipelined adder.
// The master side issues operands and accepts results; the slave side is the adder.
interface seg_pipe_adder_if
    import fp_fma_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             c_out;
    logic             ovf;

    modport master (
        output in_valid, a, b, c_in, sub, out_ready,
        input  in_ready, out_valid, sum, c_out, ovf
    );

    modport slave (
        input  in_valid, a, b, c_in, sub, out_ready,
        output in_ready, out_valid, sum, c_out, ovf
    );
endinterface

// File: rtl/seg_add.sv
// Purely combinational SEG-bit adder cell used once per pipeline stage.
// c_msb is the carry into the top bit, needed for two's-complement overflow.
module seg_add
    import fp_fma_pkg::*;
#(
    parameter int SEG = DEF_SEG
) (
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    input  logic           c_in,
    output logic [SEG-1:0] s,
    output logic           c_out,
    output logic           c_msb
);
    logic [SEG:0] full_s;

    assign full_s = {1'b0, a} + {1'b0, b} + {{SEG{1'b0}}, c_in};
    assign s      = full_s[SEG-1:0];
    assign c_out  = full_s[SEG];
    // Top bit of the sum is a^b^carry_in, so the carry into it falls out by XOR.
    assign c_msb  = a[SEG-1] ^ b[SEG-1] ^ full_s[SEG-1];

endmodule

// File: rtl/seg_pipe_adder.sv
// Pipelined adder/subtractor resolving one SEG-bit segment per stage with the carry
// handed stage to stage; unprocessed operand segments skew forward, finished sum segments deskew.
module seg_pipe_adder
    import fp_fma_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SEG   = DEF_SEG
) (
    input  logic            clk,
    input  logic            rst_n,
    seg_pipe_adder_if.slave bus
);
    localparam int NSTAGE = calc_nstage(WIDTH, SEG);

    if (!seg_cfg_ok(WIDTH, SEG)) begin : g_cfg_err
        $error("seg_pipe_adder: WIDTH must be a positive multiple of SEG");
    end

    logic              adv_s;
    logic [NSTAGE-1:0] valid_r;
    logic [WIDTH-1:0]  opa_r   [NSTAGE];
    logic [WIDTH-1:0]  opb_r   [NSTAGE];
    logic [WIDTH-1:0]  sum_r   [NSTAGE];
    logic              carry_r [NSTAGE];
    logic              ovf_r;

    logic [NSTAGE-1:0] st_v_s;
    logic [WIDTH-1:0]  st_a_s    [NSTAGE];
    logic [WIDTH-1:0]  st_b_s    [NSTAGE];
    logic [WIDTH-1:0]  st_sum_s  [NSTAGE];
    logic              st_c_s    [NSTAGE];
    logic [SEG-1:0]    seg_s     [NSTAGE];
    logic              seg_co_s  [NSTAGE];
    logic              seg_msb_s [NSTAGE];
    logic [WIDTH-1:0]  nxt_sum_s [NSTAGE];

    // A frozen output register freezes the entire pipe, so one enable serves every stage.
    assign adv_s         = bus.out_ready | ~valid_r[NSTAGE-1];
    assign bus.in_ready  = adv_s;
    assign bus.out_valid = valid_r[NSTAGE-1];
    assign bus.sum       = sum_r[NSTAGE-1];
    assign bus.c_out     = carry_r[NSTAGE-1];
    assign bus.ovf       = ovf_r;

    // Stage operand select: stage 0 takes the conditioned inputs, later stages the prior stage register.
    always_comb begin
        st_v_s[0]   = bus.in_valid;
        st_a_s[0]   = bus.a;
        st_b_s[0]   = bus.b ^ {WIDTH{bus.sub}};
        st_c_s[0]   = bus.sub ? 1'b1 : bus.c_in;
        st_sum_s[0] = {WIDTH{1'b0}};
        for (int k = 1; k < NSTAGE; k++) begin
            st_v_s[k]   = valid_r[k-1];
            st_a_s[k]   = opa_r[k-1];
            st_b_s[k]   = opb_r[k-1];
            st_c_s[k]   = carry_r[k-1];
            st_sum_s[k] = sum_r[k-1];
        end
    end

    for (genvar k = 0; k < NSTAGE; k++) begin : g_stage
        localparam logic [WIDTH-1:0] SEG_MASK = WIDTH'({SEG{1'b1}}) << (k * SEG);

        seg_add #(.SEG(SEG)) u_seg_add (
            .a     (st_a_s[k][k*SEG +: SEG]),
            .b     (st_b_s[k][k*SEG +: SEG]),
            .c_in  (st_c_s[k]),
            .s     (seg_s[k]),
            .c_out (seg_co_s[k]),
            .c_msb (seg_msb_s[k])
        );

        // Drop this stage's freshly resolved segment into the travelling partial sum.
        assign nxt_sum_s[k] = (st_sum_s[k] & ~SEG_MASK) | (WIDTH'(seg_s[k]) << (k * SEG));
    end

    // Stage registers; the last stage's result fields only change on a valid load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r <= {NSTAGE{1'b0}};
            ovf_r   <= 1'b0;
            for (int k = 0; k < NSTAGE; k++) begin
                opa_r[k]   <= {WIDTH{1'b0}};
                opb_r[k]   <= {WIDTH{1'b0}};
                sum_r[k]   <= {WIDTH{1'b0}};
                carry_r[k] <= 1'b0;
            end
        end else if (adv_s) begin
            valid_r <= st_v_s;
            for (int k = 0; k < NSTAGE; k++) begin
                opa_r[k] <= st_a_s[k];
                opb_r[k] <= st_b_s[k];
            end
            for (int k = 0; k < NSTAGE - 1; k++) begin
                sum_r[k]   <= nxt_sum_s[k];
                carry_r[k] <= seg_co_s[k];
            end
            if (st_v_s[NSTAGE-1]) begin
                sum_r[NSTAGE-1]   <= nxt_sum_s[NSTAGE-1];
                carry_r[NSTAGE-1] <= seg_co_s[NSTAGE-1];
                ovf_r             <= seg_msb_s[NSTAGE-1] ^ seg_co_s[NSTAGE-1];
            end
        end
    end

endmodule

// File: tb/tb_seg_pipe_adder.sv
// Self-checking bench for seg_pipe_adder: directed vector table, random streams with
// backpressure against an arithmetic reference model, mid-flight reset, and a single-stage build.
module tb_seg_pipe_adder;

    localparam int NST = 4;

    typedef struct packed {
        logic [31:0] sum;
        logic        c_out;
        logic        ovf;
    } res_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        c_in;
        logic        sub;
        logic [31:0] e_sum;
        logic        e_cout;
        logic        e_ovf;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   n_in   = 0;
    int   n_out  = 0;
    res_t exp_q[$];

    always #5 clk = ~clk;

    seg_pipe_adder_if #(.WIDTH(32)) bus ();
    seg_pipe_adder_if #(.WIDTH(16)) bus16 ();

    seg_pipe_adder #(.WIDTH(32), .SEG(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    seg_pipe_adder #(.WIDTH(16), .SEG(16)) dut16 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus16.slave)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Result from plain signed/unsigned integer arithmetic on the operands.
    function automatic res_t ref_model(input logic [31:0] a, input logic [31:0] b,
                                       input logic c_in, input logic sub);
        longint          sa, sb, ex;
        longint unsigned ua, ub, eu;
        res_t            r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        if (sub) begin
            ex      = sa - sb;
            eu      = ua - ub;
            r.c_out = (ua >= ub);
        end else begin
            ex      = sa + sb + longint'(c_in);
            eu      = ua + ub + {63'd0, c_in};
            r.c_out = (eu > 64'h0000_0000_FFFF_FFFF);
        end
        r.sum = eu[31:0];
        r.ovf = (ex > 64'sd2147483647) || (ex < -64'sd2147483648);
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_rand(input logic valid);
        bus.in_valid = valid;
        bus.a        = $urandom;
        bus.b        = $urandom;
        bus.c_in     = 1'($urandom_range(0, 1));
        bus.sub      = 1'($urandom_range(0, 1));
    endtask

    // Scoreboard and stall monitor, sampling on the falling edge.
    initial begin
        res_t e;
        res_t held;
        logic prev_stall;
        prev_stall = 1'b0;
        held       = '0;
        forever begin
            @(negedge clk);
            if (rst_n !== 1'b1) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    chk("stall_valid", 64'(bus.out_valid), 64'd1);
                    chk("stall_sum", 64'(bus.sum), 64'(held.sum));
                    chk("stall_cout", 64'(bus.c_out), 64'(held.c_out));
                    chk("stall_ovf", 64'(bus.ovf), 64'(held.ovf));
                end
                if (bus.out_valid && !bus.out_ready) begin
                    chk("stall_in_ready", 64'(bus.in_ready), 64'd0);
                    prev_stall = 1'b1;
                    held       = '{sum: bus.sum, c_out: bus.c_out, ovf: bus.ovf};
                end else begin
                    prev_stall = 1'b0;
                end
                if (bus.out_valid && bus.out_ready) begin
                    n_out++;
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL sb_extra: got result 0x%0h, expected no result", bus.sum);
                    end else begin
                        e = exp_q.pop_front();
                        chk("sb_sum", 64'(bus.sum), 64'(e.sum));
                        chk("sb_cout", 64'(bus.c_out), 64'(e.c_out));
                        chk("sb_ovf", 64'(bus.ovf), 64'(e.ovf));
                    end
                end
                if (bus.in_valid && bus.in_ready) begin
                    exp_q.push_back(ref_model(bus.a, bus.b, bus.c_in, bus.sub));
                    n_in++;
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no completion, expected finish before time limit");
        n_fail++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        vec_t tbl[11];
        int   base_in;
        int   base_out;
        int   cyc;
        bit   exp_v;

        tbl[0]  = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
        tbl[1]  = '{32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0};
        tbl[2]  = '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1};
        tbl[3]  = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
        tbl[4]  = '{32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
        tbl[5]  = '{32'h0000_000A, 32'h0000_0003, 1'b1, 1'b1, 32'h0000_0007, 1'b1, 1'b0};
        tbl[6]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0};
        tbl[7]  = '{32'h00FF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0100_0000, 1'b0, 1'b0};
        tbl[8]  = '{32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0001, 1'b0, 1'b0};
        tbl[9]  = '{32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 32'h2345_6789, 1'b0, 1'b0};
        tbl[10] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1};

        bus.in_valid   = 1'b0;
        bus.a          = 32'h0;
        bus.b          = 32'h0;
        bus.c_in       = 1'b0;
        bus.sub        = 1'b0;
        bus.out_ready  = 1'b1;
        bus16.in_valid  = 1'b0;
        bus16.a         = 16'h0;
        bus16.b         = 16'h0;
        bus16.c_in      = 1'b0;
        bus16.sub       = 1'b0;
        bus16.out_ready = 1'b1;

        // Reset state.
        #2 rst_n = 1'b0;
        #1;
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_sum", 64'(bus.sum), 64'd0);
        chk("rst_cout", 64'(bus.c_out), 64'd0);
        chk("rst_ovf", 64'(bus.ovf), 64'd0);
        chk("rst16_out_valid", 64'(bus16.out_valid), 64'd0);
        repeat (3) step();
        rst_n = 1'b1;

        // Directed vectors, each checked for exact latency and value.
        for (int i = 0; i < 11; i++) begin
            bus.in_valid = 1'b1;
            bus.a        = tbl[i].a;
            bus.b        = tbl[i].b;
            bus.c_in     = tbl[i].c_in;
            bus.sub      = tbl[i].sub;
            step();
            bus.in_valid = 1'b0;
            repeat (NST - 2) step();
            chk($sformatf("tbl%0d_early", i), 64'(bus.out_valid), 64'd0);
            step();
            chk($sformatf("tbl%0d_valid", i), 64'(bus.out_valid), 64'd1);
            chk($sformatf("tbl%0d_sum", i), 64'(bus.sum), 64'(tbl[i].e_sum));
            chk($sformatf("tbl%0d_cout", i), 64'(bus.c_out), 64'(tbl[i].e_cout));
            chk($sformatf("tbl%0d_ovf", i), 64'(bus.ovf), 64'(tbl[i].e_ovf));
        end
        step();

        // Back-to-back stream of 16 ops: results on consecutive cycles.
        base_out = n_out;
        for (int i = 0; i < 16 + NST; i++) begin
            drive_rand(i < 16);
            step();
            exp_v = (i >= NST - 1) && (i <= 15 + NST - 1);
            chk($sformatf("stream_valid_%0d", i), 64'(bus.out_valid), 64'(exp_v));
        end
        bus.in_valid = 1'b0;
        chk("stream_count", 64'(n_out - base_out), 64'd16);

        // Random backpressure over 1000 accepted ops.
        base_in  = n_in;
        base_out = n_out;
        cyc      = 0;
        while ((n_in - base_in) < 1000 && cyc < 20000) begin
            drive_rand($urandom_range(0, 3) != 0);
            bus.out_ready = 1'($urandom_range(0, 1));
            step();
            cyc++;
        end
        if (cyc >= 20000) begin
            n_cmp++;
            n_fail++;
            $display("FAIL bp_budget: got %0d ops accepted, expected 1000", n_in - base_in);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (NST + 2) step();
        chk("bp_drain_empty", 64'(exp_q.size()), 64'd0);
        chk("bp_count", 64'(n_out - base_out), 64'(n_in - base_in));

        // Reset with ops in flight discards them all.
        for (int i = 0; i < NST; i++) begin
            drive_rand(1'b1);
            step();
        end
        bus.in_valid = 1'b0;
        chk("rst_pre_valid", 64'(bus.out_valid), 64'd1);
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("rst_mid_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_mid_sum", 64'(bus.sum), 64'd0);
        step();
        step();
        rst_n = 1'b1;
        base_out = n_out;
        for (int i = 0; i < 5; i++) begin
            step();
            chk($sformatf("rst_idle_%0d", i), 64'(bus.out_valid), 64'd0);
        end
        for (int i = 0; i < 2; i++) begin
            drive_rand(1'b1);
            step();
        end
        bus.in_valid = 1'b0;
        repeat (NST + 1) step();
        chk("rst_after_count", 64'(n_out - base_out), 64'd2);
        chk("rst_after_empty", 64'(exp_q.size()), 64'd0);

        // Single-stage build: result one cycle after acceptance.
        bus16.in_valid = 1'b1;
        bus16.a        = 16'h7FFF;
        bus16.b        = 16'h0001;
        step();
        chk("s1_valid", 64'(bus16.out_valid), 64'd1);
        chk("s1_sum", 64'(bus16.sum), 64'h8000);
        chk("s1_ovf", 64'(bus16.ovf), 64'd1);
        chk("s1_cout", 64'(bus16.c_out), 64'd0);
        bus16.a = 16'hFFFF;
        step();
        chk("s1_wrap_sum", 64'(bus16.sum), 64'h0000);
        chk("s1_wrap_cout", 64'(bus16.c_out), 64'd1);
        chk("s1_wrap_ovf", 64'(bus16.ovf), 64'd0);
        bus16.a   = 16'h0003;
        bus16.b   = 16'h0005;
        bus16.sub = 1'b1;
        step();
        chk("s1_sub_sum", 64'(bus16.sum), 64'hFFFE);
        chk("s1_sub_cout", 64'(bus16.c_out), 64'd0);
        bus16.in_valid = 1'b0;
        step();
        chk("s1_bubble", 64'(bus16.out_valid), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
